// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the execute-stage hazard controller
package pipe_pkg;

    localparam int REG_AW = 3;

    // Operand select encodings driven to the ALU operand muxes
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // One pipeline stage slot: what the instruction in that stage will write
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic              wren;
        logic              load;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '{valid: 1'b0, dst: '0, wren: 1'b0, load: 1'b0};

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// rtl/hazard_fwd_ctrl_if.sv - decode-to-execute hazard/forwarding signal bundle
// master: decode side, drives Id* and BranchTaken, observes Stall/FlushId/FwdA/FwdB/StallCount
// slave : hazard controller, the reverse
interface hazard_fwd_ctrl_if
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) ();

    logic              IdValid;
    logic [REG_AW-1:0] IdSrc1;
    logic [REG_AW-1:0] IdSrc2;
    logic              IdUse1;
    logic              IdUse2;
    logic [REG_AW-1:0] IdDst;
    logic              IdWrEn;
    logic              IdIsLoad;
    logic              BranchTaken;
    logic              Stall;
    logic              FlushId;
    logic [1:0]        FwdA;
    logic [1:0]        FwdB;
    logic [CNT_W-1:0]  StallCount;

    modport master (
        output IdValid, IdSrc1, IdSrc2, IdUse1, IdUse2, IdDst, IdWrEn, IdIsLoad, BranchTaken,
        input  Stall, FlushId, FwdA, FwdB, StallCount
    );

    modport slave (
        input  IdValid, IdSrc1, IdSrc2, IdUse1, IdUse2, IdDst, IdWrEn, IdIsLoad, BranchTaken,
        output Stall, FlushId, FwdA, FwdB, StallCount
    );

endinterface

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - combinational forwarding-source select for one ALU operand
// src/use_src: operand register and whether it is read
// ex_s/mem_s : slots of the instructions currently in EX and MEM
// sel        : FWD_RF / FWD_EXMEM / FWD_MEMWB, valid once this operand reaches EX
module fwd_sel
    import pipe_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic              use_src,
    input  slot_t             ex_s,
    input  slot_t             mem_s,
    output logic [1:0]        sel
);

    // Slots are judged one stage before the operand enters EX, so the EX
    // producer becomes EX/MEM and the MEM producer becomes MEM/WB. The
    // nearest producer holds the newest value and therefore wins.
    always_comb begin
        sel = FWD_RF;
        if (use_src) begin
            if (ex_s.valid && ex_s.wren && (ex_s.dst == src)) begin
                sel = FWD_EXMEM;
            end else if (mem_s.valid && mem_s.wren && (mem_s.dst == src)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - execute-stage load-use stall, branch flush and operand forwarding
// clk, rst_n : clock, asynchronous active-low reset
// bus        : decode inputs (Id*, BranchTaken) in; Stall, FlushId, FwdA, FwdB, StallCount out
module hazard_fwd_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    hazard_fwd_ctrl_if.slave bus
);

    slot_t            ex_q,  ex_d;
    slot_t            mem_q, mem_d;
    slot_t            wb_q,  wb_d;
    logic [1:0]       fwd_a_q, fwd_a_d;
    logic [1:0]       fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       src1_hit;
    logic       src2_hit;
    logic       stall;
    logic       issue;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    // WB slot completes the in-flight picture but nothing here consumes it yet
    logic unused_wb;
    assign unused_wb = ^wb_q;

    fwd_sel u_fwd_a (
        .src     (bus.IdSrc1),
        .use_src (bus.IdUse1),
        .ex_s    (ex_q),
        .mem_s   (mem_q),
        .sel     (sel_a)
    );

    fwd_sel u_fwd_b (
        .src     (bus.IdSrc2),
        .use_src (bus.IdUse2),
        .ex_s    (ex_q),
        .mem_s   (mem_q),
        .sel     (sel_b)
    );

    // A load in EX has no result yet, so a dependent instruction must wait
    // one cycle; a taken branch discards decode anyway, so it never stalls.
    always_comb begin
        src1_hit = bus.IdUse1 && (bus.IdSrc1 == ex_q.dst);
        src2_hit = bus.IdUse2 && (bus.IdSrc2 == ex_q.dst);
        stall    = bus.IdValid && ex_q.valid && ex_q.wren && ex_q.load &&
                   (src1_hit || src2_hit) && !bus.BranchTaken;
        issue    = bus.IdValid && !stall && !bus.BranchTaken;
    end

    always_comb begin
        wb_d  = mem_q;
        mem_d = ex_q;
        ex_d  = SLOT_BUBBLE;
        if (issue) begin
            ex_d.valid = 1'b1;
            ex_d.dst   = bus.IdDst;
            ex_d.wren  = bus.IdWrEn;
            ex_d.load  = bus.IdIsLoad;
        end

        // Bubbles entering EX must never steer the operand muxes
        fwd_a_d = issue ? sel_a : FWD_RF;
        fwd_b_d = issue ? sel_b : FWD_RF;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= SLOT_BUBBLE;
            mem_q       <= SLOT_BUBBLE;
            wb_q        <= SLOT_BUBBLE;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.Stall      = stall;
    assign bus.FlushId    = bus.BranchTaken;
    assign bus.FwdA       = fwd_a_q;
    assign bus.FwdB       = fwd_b_q;
    assign bus.StallCount = stall_cnt_q;

endmodule
